// File: rtl/seg_dp_pkg.sv
// seg_dp_pkg: shared types, constants and the saturating adder for the segmentation DP blocks.
package seg_dp_pkg;

    localparam int BW    = 32;
    localparam int I_MAX = 160;
    localparam int IW    = $clog2(I_MAX);

    localparam logic signed [BW-1:0] F_MAX = {1'b0, {(BW-1){1'b1}}};
    localparam logic signed [BW-1:0] F_MIN = {1'b1, {(BW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, WRITE} state_t;

    typedef struct packed {
        logic                 valid;
        logic [IW-1:0]        j;
        logic signed [BW-1:0] emin;
        logic                 first;
    } samp_t;

    // One extra bit of headroom; the two top bits disagree exactly on overflow.
    function automatic logic signed [BW-1:0] sat_add(input logic signed [BW-1:0] a, input logic signed [BW-1:0] b);
        logic [BW:0] s;
        s = {a[BW-1], a} + {b[BW-1], b};
        return (s[BW] ^ s[BW-1]) ? (s[BW] ? F_MIN : F_MAX) : s[BW-1:0];
    endfunction

endpackage

// File: rtl/dp_align_pipe.sv
// dp_align_pipe: delays accepted emin samples so they meet the cost-BRAM read data.
module dp_align_pipe
    import seg_dp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  samp_t d,
    output samp_t q,
    output logic  pending
);

    samp_t sr [DEPTH];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
        end else begin
            sr[0] <= d;
            for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        end
    end

    always_comb begin
        pending = 1'b0;
        for (int k = 0; k < DEPTH; k++) pending = pending | sr[k].valid;
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/seg_dp_update.sv
// seg_dp_update: F(i) = min_j sat(F(j-1) + Emin(j,i)) with arg-min backpointer, written once per frame.
module seg_dp_update
    import seg_dp_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [IW-1:0]        i_in,
    input  logic [IW-1:0]        j_in,
    input  logic signed [BW-1:0] emin_in,
    input  logic                 emin_valid_in,
    output logic [IW-1:0]        f_req,
    input  logic signed [BW-1:0] f_resp,
    output logic [IW-1:0]        wr_addr,
    output logic signed [BW-1:0] wr_f,
    output logic [IW-1:0]        wr_b,
    output logic                 wr_en,
    output logic                 done_out,
    output logic                 busy_out,
    output logic                 err_out
);

    state_t               state, next_state;
    logic [IW-1:0]        i_reg, expect_j, argmin;
    logic signed [BW-1:0] min_f, addend, sum;
    logic                 accept, pending, bad;
    samp_t                d, q;

    assign accept = (state == ACCUM) && emin_valid_in;
    assign d      = {accept, j_in, emin_in, j_in == '0};

    dp_align_pipe #(.DEPTH(RD_LAT)) u_align (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .d       (d),
        .q       (q),
        .pending (pending)
    );

    assign addend = q.first ? '0 : f_resp;
    assign sum    = sat_add(addend, q.emin);
    assign bad    = (accept && (j_in != expect_j || j_in > i_reg))
                 || (emin_valid_in && state != ACCUM)
                 || (start_in && state != IDLE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= next_state;
    end

    // DRAIN waits until the pipe is empty, so the last compare has already landed in min_f.
    always_comb begin
        next_state = state;
        if (state == IDLE && start_in)       next_state = ACCUM;
        else if (accept && j_in == i_reg)    next_state = DRAIN;
        else if (state == DRAIN && !pending) next_state = WRITE;
        else if (state == WRITE)             next_state = IDLE;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            i_reg    <= '0;
            expect_j <= '0;
            argmin   <= '0;
            min_f    <= F_MAX;
            err_out  <= 1'b0;
        end else begin
            err_out <= err_out | bad;
            if (state == IDLE && start_in) begin
                i_reg    <= i_in;
                expect_j <= '0;
                argmin   <= '0;
                min_f    <= F_MAX;
            end
            if (accept) expect_j <= expect_j + 1'b1;
            if (q.valid && sum < min_f) begin
                min_f  <= sum;
                argmin <= q.j;
            end
        end
    end

    always_comb begin
        wr_en    = state == WRITE;
        done_out = state == WRITE;
        busy_out = state != IDLE;
        wr_addr  = wr_en ? i_reg : '0;
        wr_f     = wr_en ? min_f : '0;
        wr_b     = wr_en ? argmin : '0;
        f_req    = (accept && j_in != '0) ? j_in - 1'b1 : '0;
    end

endmodule

// File: tb/tb_seg_dp_update.sv
// tb_seg_dp_update: directed frames against a 2-cycle BRAM model with hand-computed F/B results.
module tb_seg_dp_update;
    import seg_dp_pkg::*;

    logic                 clk_in = 0, rst_in = 0, start_in = 0, emin_valid_in = 0;
    logic [IW-1:0]        i_in = '0, j_in = '0;
    logic signed [BW-1:0] emin_in = '0;
    logic [IW-1:0]        f_req, wr_addr, wr_b;
    logic signed [BW-1:0] f_resp, wr_f, rd1, rd2;
    logic                 wr_en, done_out, busy_out, err_out;

    logic signed [BW-1:0] mem [I_MAX];
    int                   js [8];
    int                   em [8];
    int                   n_tests = 0, n_fail = 0;
    int                   lat, seen;
    logic [63:0]          cap_a, cap_f, cap_b, cap_d;

    seg_dp_update #(.RD_LAT(2)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start_in      (start_in),
        .i_in          (i_in),
        .j_in          (j_in),
        .emin_in       (emin_in),
        .emin_valid_in (emin_valid_in),
        .f_req         (f_req),
        .f_resp        (f_resp),
        .wr_addr       (wr_addr),
        .wr_f          (wr_f),
        .wr_b          (wr_b),
        .wr_en         (wr_en),
        .done_out      (done_out),
        .busy_out      (busy_out),
        .err_out       (err_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        rd1 <= mem[f_req];
        rd2 <= rd1;
    end
    assign f_resp = rd2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Streams js/em[0..n-1] for frame i and records the write, measured in cycles after the last accept.
    task automatic run_frame(input int i, input int n, input bit poke_start);
        @(negedge clk_in);
        start_in = 1;
        i_in     = IW'(i);
        @(negedge clk_in);
        start_in = 0;
        check("busy_after_start", busy_out, 1);
        for (int k = 0; k < n; k++) begin
            emin_valid_in = 1;
            j_in          = IW'(js[k]);
            emin_in       = em[k];
            #1 check("f_req", f_req, js[k] == 0 ? 0 : js[k] - 1);
            @(negedge clk_in);
        end
        emin_valid_in = 0;
        lat = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            if (wr_en) begin
                lat   = k;
                cap_a = 64'(wr_addr);
                cap_f = 64'(unsigned'(wr_f));
                cap_b = 64'(wr_b);
                cap_d = 64'(done_out);
            end
            start_in = poke_start && k == 2;
            if (lat == 0) @(negedge clk_in);
        end
        start_in = 0;
        check("wr_latency", lat, 4);
        @(negedge clk_in);
        check("wr_en_one_cycle", wr_en, 0);
        check("idle_after_done", busy_out, 0);
    endtask

    initial begin
        for (int k = 0; k < I_MAX; k++) mem[k] = '0;
        #12;
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy_out, 0);
        check("rst_err", err_out, 0);
        rst_in = 1;

        js[0] = 0; em[0] = 500;
        run_frame(0, 1, 0);
        check("t1_addr", cap_a, 0);
        check("t1_f", cap_f, 500);
        check("t1_b", cap_b, 0);
        check("t1_done", cap_d, 1);

        mem[0] = 10; mem[1] = 4; mem[2] = 7;
        js = '{0, 1, 2, 3, 0, 0, 0, 0};
        em = '{100, 20, 30, 2, 0, 0, 0, 0};
        run_frame(3, 4, 0);
        check("t2_addr", cap_a, 3);
        check("t2_f", cap_f, 9);
        check("t2_b", cap_b, 3);

        mem[0] = 2; mem[1] = 5;
        js = '{0, 1, 2, 0, 0, 0, 0, 0};
        em = '{50, 10, 7, 0, 0, 0, 0, 0};
        run_frame(2, 3, 0);
        check("t3_tie_f", cap_f, 12);
        check("t3_tie_b", cap_b, 1);

        mem[0] = 32'sh7FFF_FFF0;
        js = '{0, 1, 0, 0, 0, 0, 0, 0};
        em = '{5, 32'sh100, 0, 0, 0, 0, 0, 0};
        run_frame(1, 2, 0);
        check("t4_sat_f", cap_f, 5);
        check("t4_sat_b", cap_b, 0);
        check("t4_no_err", err_out, 0);

        mem[0] = 10; mem[1] = 4;
        js = '{0, 2, 0, 0, 0, 0, 0, 0};
        em = '{50, 1, 0, 0, 0, 0, 0, 0};
        run_frame(2, 2, 1);
        check("t5_err", err_out, 1);
        check("t5_f", cap_f, 5);
        check("t5_b", cap_b, 2);
        @(negedge clk_in);
        check("t5_start_ignored", busy_out, 0);
        check("t5_err_sticky", err_out, 1);

        @(negedge clk_in);
        start_in = 1;
        i_in     = 3;
        @(negedge clk_in);
        start_in = 0;
        emin_valid_in = 1; j_in = 0; emin_in = 100;
        @(negedge clk_in);
        j_in = 1; emin_in = 20;
        #2 rst_in = 0;
        #1;
        check("t6_wr_en", wr_en, 0);
        check("t6_busy", busy_out, 0);
        check("t6_err", err_out, 0);
        check("t6_f_req", f_req, 0);
        check("t6_wr_f", wr_f, 0);
        emin_valid_in = 0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            if (wr_en || done_out) seen++;
            if (k == 3) rst_in = 1;
        end
        check("t6_no_write", seen, 0);
        mem[0] = 10; mem[1] = 4; mem[2] = 7;
        js = '{0, 1, 2, 3, 0, 0, 0, 0};
        em = '{100, 20, 30, 2, 0, 0, 0, 0};
        run_frame(3, 4, 0);
        check("t6_f", cap_f, 9);
        check("t6_b", cap_b, 3);
        check("t6_err_clear", err_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
